// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one outstanding load/store, fixed BUSY latency,
// sign-extending sub-word loads, lane-merging sub-word stores, misalignment flagging.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  MemWrite,
  input  logic [1:0]  MemRead,
  output logic        ReqReady,
  output logic        Stall,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        Misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic          op_present;
  logic [1:0]    req_size;
  logic          req_mis;
  logic          finish;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic [31:0]   load_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^Address[31:AW+2];

  assign op_present = ReqValid && ((MemWrite != 2'b00) || (MemRead != 2'b00));
  // Write wins over a simultaneous read; the read is simply dropped.
  assign req_size   = (MemWrite != 2'b00) ? MemWrite : MemRead;
  assign req_mis    = ((req_size == SZ_WORD) && (Address[1:0] != 2'b00)) ||
                      ((req_size == SZ_HALF) && Address[0]);
  assign finish     = (state_q == BUSY) && (cnt_q == 3'd0);

  assign cur_word = mem_q[addr_q[AW+1:2]];
  assign ld_byte  = cur_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = cur_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    merged_word = cur_word;
    unique case (size_q)
      SZ_WORD: merged_word = wdata_q;
      SZ_HALF: merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      SZ_BYTE: merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      default: merged_word = cur_word;
    endcase
  end

  always_comb begin
    load_word = '0;
    unique case (size_q)
      SZ_WORD: load_word = cur_word;
      SZ_HALF: load_word = {{16{ld_half[15]}}, ld_half};
      SZ_BYTE: load_word = {{24{ld_byte[7]}}, ld_byte};
      default: load_word = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    mis_d      = mis_q;
    unique case (state_q)
      IDLE: begin
        if (op_present) begin
          addr_d     = Address[AW+1:0];
          wdata_d    = WriteData;
          size_d     = req_size;
          is_write_d = (MemWrite != 2'b00);
          rdata_d    = '0;
          mis_d      = req_mis;
          if (req_mis) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = RESP;
          rdata_d = is_write_q ? '0 : load_word;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      mis_q      <= mis_d;
    end
  end

  // Array is not reset; a reset on the final BUSY edge suppresses the commit.
  always_ff @(posedge Clk) begin
    if (!Reset && finish && is_write_q) begin
      mem_q[addr_q[AW+1:2]] <= merged_word;
    end
  end

  assign ReqReady   = (state_q == IDLE);
  assign Stall      = ((state_q == IDLE) && op_present) || (state_q == BUSY);
  assign RespValid  = (state_q == RESP);
  assign ReadData   = rdata_q;
  assign Misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  MemWrite;
  logic [1:0]  MemRead;
  logic        ReqReady;
  logic        Stall;
  logic        RespValid;
  logic [31:0] ReadData;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int prev_issue_cyc = 0;
  logic [32:0] exp_q[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ReqReady   (ReqReady),
    .Stall      (Stall),
    .RespValid  (RespValid),
    .ReadData   (ReadData),
    .Misaligned (Misaligned)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, then follow it to its response and compare against the scoreboard.
  task automatic access(input string tag, input logic [1:0] mw, input logic [1:0] mr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input int exp_stall);
    int stalls;
    bit done;
    logic [32:0] e;
    @(negedge Clk);
    chk({tag, "/ready"}, {31'd0, ReqReady}, 32'd1);
    chk({tag, "/no_resp_before"}, {31'd0, RespValid}, 32'd0);
    ReqValid  = 1'b1;
    MemWrite  = mw;
    MemRead   = mr;
    Address   = a;
    WriteData = wd;
    prev_issue_cyc = issue_cyc;
    issue_cyc = cyc;
    exp_q.push_back({exp_rd, exp_mis});
    #1;
    stalls = Stall ? 1 : 0;
    @(negedge Clk);
    ReqValid = 1'b0;
    MemWrite = 2'b00;
    MemRead  = 2'b00;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      if (RespValid) begin
        e = exp_q.pop_front();
        chk({tag, "/rdata"}, ReadData, e[32:1]);
        chk({tag, "/misaligned"}, {31'd0, Misaligned}, {31'd0, e[0]});
        chk({tag, "/stall_in_resp"}, {31'd0, Stall}, 32'd0);
        chk({tag, "/stall_cycles"}, 32'(stalls), 32'(exp_stall));
        done = 1'b1;
      end else begin
        if (Stall) stalls++;
        @(negedge Clk);
      end
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s/timeout: observed no RespValid expected RespValid within 16 cycles", tag);
    end
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; Address = '0; WriteData = '0;
    MemWrite = 2'b00; MemRead = 2'b00;
    repeat (2) @(negedge Clk);
    chk("reset/ReqReady", {31'd0, ReqReady}, 32'd1);
    chk("reset/Stall", {31'd0, Stall}, 32'd0);
    chk("reset/RespValid", {31'd0, RespValid}, 32'd0);
    chk("reset/ReadData", ReadData, 32'd0);
    chk("reset/Misaligned", {31'd0, Misaligned}, 32'd0);
    Reset = 1'b0;

    // Word store, sign-extended sub-word loads.
    access("sw_10",  2'b01, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, LAT + 1);
    access("lb_13",  2'b00, 2'b11, 32'h13, 32'h0,       32'hFFFFFFDE, 1'b0, LAT + 1);
    access("lh_10",  2'b00, 2'b10, 32'h10, 32'h0,       32'hFFFFBEEF, 1'b0, LAT + 1);
    // Partial store merges.
    access("sb_11",  2'b11, 2'b00, 32'h11, 32'h0000007F, 32'h0,       1'b0, LAT + 1);
    access("lw_10a", 2'b00, 2'b01, 32'h10, 32'h0,       32'hDEAD7FEF, 1'b0, LAT + 1);
    access("lb_11",  2'b00, 2'b11, 32'h11, 32'h0,       32'h0000007F, 1'b0, LAT + 1);
    access("sh_12",  2'b10, 2'b00, 32'h12, 32'h00001234, 32'h0,       1'b0, LAT + 1);
    access("lw_10b", 2'b00, 2'b01, 32'h10, 32'h0,       32'h12347FEF, 1'b0, LAT + 1);
    // Misaligned accesses leave memory untouched.
    access("lw_12_mis", 2'b00, 2'b01, 32'h12, 32'h0,        32'h0,        1'b1, 1);
    access("lw_10c",    2'b00, 2'b01, 32'h10, 32'h0,        32'h12347FEF, 1'b0, LAT + 1);
    access("sh_11_mis", 2'b10, 2'b00, 32'h11, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    access("lw_10d",    2'b00, 2'b01, 32'h10, 32'h0,        32'h12347FEF, 1'b0, LAT + 1);

    // Reset during the first BUSY cycle: no response, no commit.
    @(negedge Clk);
    ReqValid = 1'b1; MemWrite = 2'b01; MemRead = 2'b00;
    Address = 32'h20; WriteData = 32'h12345678;
    @(negedge Clk);
    ReqValid = 1'b0; MemWrite = 2'b00;
    chk("rst_mid/busy_stall", {31'd0, Stall}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_mid/ReqReady", {31'd0, ReqReady}, 32'd1);
    chk("rst_mid/Stall", {31'd0, Stall}, 32'd0);
    chk("rst_mid/ReadData", ReadData, 32'd0);
    chk("rst_mid/Misaligned", {31'd0, Misaligned}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid/no_resp", {31'd0, RespValid}, 32'd0);
      @(negedge Clk);
    end
    access("lw_20", 2'b00, 2'b01, 32'h20, 32'h0, 32'h0, 1'b0, LAT + 1);

    // Simultaneous write+read: write wins, ReadData is zero.
    access("swlw_40", 2'b01, 2'b01, 32'h40, 32'hA5A5A5A5, 32'h0,        1'b0, LAT + 1);
    access("lw_40",   2'b00, 2'b01, 32'h40, 32'h0,        32'hA5A5A5A5, 1'b0, LAT + 1);

    // Empty request: no stall, no response.
    @(negedge Clk);
    ReqValid = 1'b1; MemWrite = 2'b00; MemRead = 2'b00; Address = 32'h40;
    #1;
    chk("empty/Stall", {31'd0, Stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("empty/no_resp", {31'd0, RespValid}, 32'd0);
      chk("empty/ready", {31'd0, ReqReady}, 32'd1);
    end
    ReqValid = 1'b0;

    // Address wrap plus back-to-back issue.
    access("sw_1000", 2'b01, 2'b00, 32'h1000, 32'hCAFEF00D, 32'h0,        1'b0, LAT + 1);
    access("lw_0",    2'b00, 2'b01, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, LAT + 1);
    chk("b2b/interval", 32'(issue_cyc - prev_issue_cyc), 32'(LAT + 2));

    chk("scoreboard/empty", 32'(exp_q.size()), 32'd0);
    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
